// File: rtl/mem_pkg.sv
// Shared definitions for the program/data memory arbiter.
//   MEM_AW / MEM_DW   default address / data widths of the 256x16 memory
//   MEM_STARVE_MAX    default starvation limit for the CPU port
//   owner_t           current-cycle grant encoding driven on mem_arbiter.owner
package mem_pkg;

  localparam int MEM_AW         = 8;
  localparam int MEM_DW         = 16;
  localparam int MEM_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_HOST = 2'b01,
    OWN_CPU  = 2'b10
  } owner_t;

endpackage

// File: rtl/arb_prio2.sv
// Two-input fixed-priority selector with a starvation guard.
//   clk, reset : clock, synchronous active-high reset
//   req_hi     : high-priority request (host)
//   req_lo     : low-priority request, already qualified (CPU eligible)
//   gnt_hi/lo  : one-hot (or zero) grant, combinational in the request cycle
// starve_cnt counts consecutive cycles where req_lo was denied; once it hits
// STARVE_MAX the low side wins the next contended cycle.
module arb_prio2 #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req_hi,
  input  logic req_lo,
  output logic gnt_hi,
  output logic gnt_lo
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == CW'(STARVE_MAX));

  // Grants are forced low while reset is held so nothing reaches memory.
  assign gnt_lo = ~reset & req_lo & (~req_hi | starved);
  assign gnt_hi = ~reset & req_hi & ~gnt_lo;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!req_lo || gnt_lo) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port program/data memory between the host (loader/debug)
// and the CPU. Host has priority; the CPU is guaranteed a slot after
// STARVE_MAX consecutive denials while running.
//   host_*  : host request/grant/read-return port
//   cpu_*   : CPU request/grant/read-return port (ignored while cpu_run=0)
//   mem_*   : memory macro port, mem_rdata has 1-cycle registered latency
//   owner   : current-cycle grant (00 none, 01 host, 10 CPU)
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW         = MEM_AW,
  parameter int DW         = MEM_DW,
  parameter int STARVE_MAX = MEM_STARVE_MAX
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_run,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  logic          cpu_elig;
  logic          rd_host, rd_cpu;
  logic [DW-1:0] host_rdata_q, cpu_rdata_q;

  assign cpu_elig = cpu_req & cpu_run;

  arb_prio2 #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req_hi (host_req),
    .req_lo (cpu_elig),
    .gnt_hi (host_gnt),
    .gnt_lo (cpu_gnt)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner     = OWN_NONE;
    if (host_gnt) begin
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      owner     = OWN_HOST;
    end else if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      owner     = OWN_CPU;
    end
  end

  // Return routing follows who was granted last cycle, not the current owner,
  // so a new grant can overlap the returning read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_host      <= 1'b0;
      rd_cpu       <= 1'b0;
      host_rdata_q <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      rd_host <= host_gnt & ~host_we;
      rd_cpu  <= cpu_gnt & ~cpu_we;
      if (host_rvalid) host_rdata_q <= mem_rdata;
      if (cpu_rvalid)  cpu_rdata_q  <= mem_rdata;
    end
  end

  // Reset masks the return path immediately, even with a read in flight.
  assign host_rvalid = rd_host & ~reset;
  assign cpu_rvalid  = rd_cpu & ~reset;
  assign host_rdata  = reset ? '0 : (host_rvalid ? mem_rdata : host_rdata_q);
  assign cpu_rdata   = reset ? '0 : (cpu_rvalid ? mem_rdata : cpu_rdata_q);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_run;
  logic        host_req, host_we;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_gnt, host_rvalid;
  logic [15:0] host_rdata;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [1:0]  owner;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(8), .DW(16), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset), .cpu_run(cpu_run),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
  );

  // Memory macro model: synchronous write, registered read.
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    logic        hr, hw;
    logic [7:0]  ha;
    logic [15:0] hd;
    logic        run, cr, cw;
    logic [7:0]  ca;
    logic [15:0] cd;
    logic        e_hg, e_cg;
    logic [1:0]  e_own;
    logic        e_men, e_mwe;
    logic [7:0]  e_maddr;
    logic        e_hv;
    logic [15:0] e_hdata;
    logic        e_cv;
    logic [15:0] e_cdata;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t v [30];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic hr, hw, input logic [7:0] ha, input logic [15:0] hd,
    input logic run, cr, cw, input logic [7:0] ca, input logic [15:0] cd,
    input logic e_hg, e_cg, input logic [1:0] e_own, input logic e_men, e_mwe,
    input logic [7:0] e_maddr, input logic e_hv, input logic [15:0] e_hdata,
    input logic e_cv, input logic [15:0] e_cdata, input logic [2:0] e_cnt);
    vec_t r;
    r.hr = hr; r.hw = hw; r.ha = ha; r.hd = hd;
    r.run = run; r.cr = cr; r.cw = cw; r.ca = ca; r.cd = cd;
    r.e_hg = e_hg; r.e_cg = e_cg; r.e_own = e_own; r.e_men = e_men; r.e_mwe = e_mwe;
    r.e_maddr = e_maddr; r.e_hv = e_hv; r.e_hdata = e_hdata;
    r.e_cv = e_cv; r.e_cdata = e_cdata; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic drive(input logic hr, hw, input logic [7:0] ha, input logic [15:0] hd,
                       input logic run, cr, cw, input logic [7:0] ca, input logic [15:0] cd);
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    cpu_run = run; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
  endtask

  initial begin
    // Host-only load, cpu_run=0 while CPU keeps requesting
    v[0]  = mk(1,1,8'h30,16'h5487, 0,1,0,8'h10,0, 1,0,2'b01,1,1,8'h30, 0,16'h0,    0,16'h0,    0);
    v[1]  = mk(1,0,8'h30,0,        0,1,0,8'h10,0, 1,0,2'b01,1,0,8'h30, 0,16'h0,    0,16'h0,    0);
    v[2]  = mk(0,0,0,0,            0,1,0,8'h10,0, 0,0,2'b00,0,0,8'h00, 1,16'h5487, 0,16'h0,    0);
    v[3]  = mk(0,0,0,0,            0,1,0,8'h10,0, 0,0,2'b00,0,0,8'h00, 0,16'h5487, 0,16'h0,    0);
    // CPU-only back-to-back reads 0x30..0x34
    v[4]  = mk(0,0,0,0, 1,1,0,8'h30,0, 0,1,2'b10,1,0,8'h30, 0,16'h5487, 0,16'h0,    0);
    v[5]  = mk(0,0,0,0, 1,1,0,8'h31,0, 0,1,2'b10,1,0,8'h31, 0,16'h5487, 1,16'h5487, 0);
    v[6]  = mk(0,0,0,0, 1,1,0,8'h32,0, 0,1,2'b10,1,0,8'h32, 0,16'h5487, 1,16'h6666, 0);
    v[7]  = mk(0,0,0,0, 1,1,0,8'h33,0, 0,1,2'b10,1,0,8'h33, 0,16'h5487, 1,16'h00FF, 0);
    v[8]  = mk(0,0,0,0, 1,1,0,8'h34,0, 0,1,2'b10,1,0,8'h34, 0,16'h5487, 1,16'h0BED, 0);
    v[9]  = mk(0,0,0,0, 1,0,0,0,0,     0,0,2'b00,0,0,8'h00, 0,16'h5487, 1,16'hABCD, 0);
    v[10] = mk(0,0,0,0, 1,0,0,0,0,     0,0,2'b00,0,0,8'h00, 0,16'h5487, 0,16'hABCD, 0);
    // Contention: H,H,H,H,C,H,H,H,H,C with starve_cnt 0..4
    for (int i = 0; i < 10; i++) begin
      logic c;
      c = (i % 5 == 4);
      v[11+i] = mk(1,1,8'h60,16'hAAAA, 1,1,1,8'h61,16'hBBBB,
                   !c, c, c ? 2'b10 : 2'b01, 1, 1, c ? 8'h61 : 8'h60,
                   0,16'h5487, 0,16'hABCD, 3'(i % 5));
    end
    v[21] = mk(0,0,0,0, 1,0,0,0,0, 0,0,2'b00,0,0,8'h00, 0,16'h5487, 0,16'hABCD, 0);
    // Read-return routing: host read 0x40 then CPU read 0x41
    v[22] = mk(1,0,8'h40,0, 1,0,0,0,0,     1,0,2'b01,1,0,8'h40, 0,16'h5487, 0,16'hABCD, 0);
    v[23] = mk(0,0,0,0,     1,1,0,8'h41,0, 0,1,2'b10,1,0,8'h41, 1,16'h1111, 0,16'hABCD, 0);
    v[24] = mk(0,0,0,0,     1,0,0,0,0,     0,0,2'b00,0,0,8'h00, 0,16'h1111, 1,16'h2222, 0);
    v[25] = mk(0,0,0,0,     1,0,0,0,0,     0,0,2'b00,0,0,8'h00, 0,16'h1111, 0,16'h2222, 0);
    // cpu_run drop with a CPU read in flight
    v[26] = mk(0,0,0,0,              1,1,0,8'h30,0, 0,1,2'b10,1,0,8'h30, 0,16'h1111, 0,16'h2222, 0);
    v[27] = mk(1,1,8'h70,16'h1234,   0,1,0,8'h31,0, 1,0,2'b01,1,1,8'h70, 0,16'h1111, 1,16'h5487, 0);
    v[28] = mk(0,0,0,0,              0,1,0,8'h31,0, 0,0,2'b00,0,0,8'h00, 0,16'h1111, 0,16'h5487, 0);
    v[29] = mk(0,0,0,0,              0,1,0,8'h31,0, 0,0,2'b00,0,0,8'h00, 0,16'h1111, 0,16'h5487, 0);

    for (int a = 0; a < 256; a++) mem[a] = 16'h0;
    mem[8'h31] = 16'h6666; mem[8'h32] = 16'h00FF; mem[8'h33] = 16'h0BED;
    mem[8'h34] = 16'hABCD; mem[8'h40] = 16'h1111; mem[8'h41] = 16'h2222;
    mem_rdata = 16'h0;

    // Reset with requests pending: nothing may be granted
    reset = 1'b1;
    drive(1,0,8'h05,0, 1,1,0,8'h06,0);
    @(negedge clk); @(negedge clk); #1;
    chk("rst_host_gnt", 32'(host_gnt), 0);
    chk("rst_cpu_gnt",  32'(cpu_gnt), 0);
    chk("rst_mem_en",   32'(mem_en), 0);
    chk("rst_owner",    32'(owner), 0);
    chk("rst_host_rdata", 32'(host_rdata), 0);
    chk("rst_cpu_rdata",  32'(cpu_rdata), 0);
    chk("rst_starve",   32'(dut.u_arb.starve_cnt), 0);
    drive(0,0,0,0, 0,0,0,0,0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_host_rvalid", 32'(host_rvalid), 0);
    chk("post_rst_cpu_rvalid",  32'(cpu_rvalid), 0);

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      drive(v[i].hr, v[i].hw, v[i].ha, v[i].hd, v[i].run, v[i].cr, v[i].cw, v[i].ca, v[i].cd);
      #1;
      chk($sformatf("v%0d_host_gnt", i),   32'(host_gnt),    32'(v[i].e_hg));
      chk($sformatf("v%0d_cpu_gnt", i),    32'(cpu_gnt),     32'(v[i].e_cg));
      chk($sformatf("v%0d_owner", i),      32'(owner),       32'(v[i].e_own));
      chk($sformatf("v%0d_mem_en", i),     32'(mem_en),      32'(v[i].e_men));
      chk($sformatf("v%0d_mem_we", i),     32'(mem_we),      32'(v[i].e_mwe));
      chk($sformatf("v%0d_mem_addr", i),   32'(mem_addr),    32'(v[i].e_maddr));
      chk($sformatf("v%0d_host_rvalid", i),32'(host_rvalid), 32'(v[i].e_hv));
      chk($sformatf("v%0d_host_rdata", i), 32'(host_rdata),  32'(v[i].e_hdata));
      chk($sformatf("v%0d_cpu_rvalid", i), 32'(cpu_rvalid),  32'(v[i].e_cv));
      chk($sformatf("v%0d_cpu_rdata", i),  32'(cpu_rdata),   32'(v[i].e_cdata));
      chk($sformatf("v%0d_starve", i),     32'(dut.u_arb.starve_cnt), 32'(v[i].e_cnt));
    end

    // Write data of the contention phase reached the memory from the right port
    chk("mem60_host_wr", 32'(mem[8'h60]), 32'h0000AAAA);
    chk("mem61_cpu_wr",  32'(mem[8'h61]), 32'h0000BBBB);

    // Reset mid-read: CPU read granted, reset asserted the very next cycle
    @(negedge clk);
    drive(0,0,0,0, 1,1,0,8'h32,0);
    #1;
    chk("mr_cpu_gnt", 32'(cpu_gnt), 1);
    @(negedge clk);
    reset = 1'b1;
    drive(1,0,8'h33,0, 1,1,0,8'h33,0);
    #1;
    chk("mr_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("mr_cpu_rdata",  32'(cpu_rdata), 0);
    chk("mr_mem_en",     32'(mem_en), 0);
    chk("mr_host_gnt",   32'(host_gnt), 0);
    chk("mr_cpu_gnt_rst",32'(cpu_gnt), 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0,0,0,0, 1,0,0,0,0);
    #1;
    chk("mr_rel_cpu_rvalid",  32'(cpu_rvalid), 0);
    chk("mr_rel_host_rvalid", 32'(host_rvalid), 0);
    chk("mr_rel_cpu_rdata",   32'(cpu_rdata), 0);
    chk("mr_rel_host_rdata",  32'(host_rdata), 0);
    @(negedge clk); #1;
    chk("mr_rel2_cpu_rvalid", 32'(cpu_rvalid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
